inv_add_round_key: RTL and testbench
====================================

Name: inv_add_round_key

Overview:
- Registered AddRoundKey stage of the iterative AES-128 decryption datapath. Sits directly upstream of InvMixColumns.
- Holds the 11 round keys in an internal key bank and tracks the round index itself (descending NR..0).
- XORs each accepted 128-bit state with the matching round key and tells downstream whether InvMixColumns applies to that beat.
- Valid/ready handshake on both sides, one pipeline register, full throughput.

Parameters:
- NR, 10, number of AES rounds; key bank depth is NR+1.
- SW, 128, state/key width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_we  input  1  round-key write strobe.
- key_addr  input  4  round-key index, 0..NR.
- key_wdata  input  [0:SW-1]  round key; byte 0 in bits [0:7].
- in_valid  input  1  upstream state valid.
- in_ready  output  1  stage can accept this cycle.
- in_state  input  [0:SW-1]  state, same byte order as key_wdata.
- in_first  input  1  beat is the first (ciphertext) beat of a new block.
- out_valid  output  1  out_* hold a result.
- out_ready  input  1  downstream accepts.
- out_state  output  [0:SW-1]  in_state XOR key[round].
- out_round  output  4  round index used for this beat.
- out_mix  output  1  1 when 1 <= out_round <= NR-1; downstream applies InvMixColumns only then.
- out_last  output  1  1 when out_round == 0; out_state is plaintext.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - out_valid, out_state, out_round, out_mix, out_last all 0.
  - Internal round counter rnd = NR.
  - All key bank entries = 0.
- in_ready = !out_valid || out_ready (combinational). Stalls only when the output register is full and not being drained.
- Accept happens when in_valid && in_ready. On accept, the output register loads on the next edge:
  - r = in_first ? NR : rnd
  - out_state = in_state ^ key[r]
  - out_round = r
  - out_mix = (r != 0 && r != NR)
  - out_last = (r == 0)
  - out_valid = 1
- Latency is 1 cycle from accept to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- Counter update on accept:
  - rnd = (r == 0) ? NR : r-1.
  - Wrap-around: after the round-0 beat, the next beat uses NR even without in_first.
- in_first is honoured on any beat. Asserting it mid-block aborts the current block; no error flag is raised.
- Drain when out_valid && out_ready && !accept: out_valid goes to 0. Other out_* fields hold their last values.
- Simultaneous drain and accept: the register reloads and out_valid stays 1. No bubble.
- Stall when out_valid && !out_ready: all out_* hold stable; rnd is unchanged; in_valid is ignored.
- Key writes:
  - key_we with key_addr <= NR writes that entry on the next edge.
  - key_addr > NR is ignored.
  - Writes are accepted regardless of handshake state.
- Same-cycle write and accept to the same index: the XOR uses the old key (read-before-write). The new key applies from the next accept.
- Arithmetic is pure bitwise XOR over SW bits; no carries, no byte reordering.
- Reset mid-block: the held output is discarded and rnd returns to NR. The next accepted beat uses key[NR] even if in_first = 0.

Test Plan:
- Load FIPS-197 C.1 round-10 key 13111d7fe3944a17f307a78b4d2b30c5 at addr 10. Send in_state 69c4e0d86a7b0430d8cdb78070b4c55a with in_first=1, out_ready=1 -> 1 cycle later: out_state 7ad5fda789ef4e272bca100b3d9ff59f, out_round 10, out_mix 0, out_last 0.
- Load keys k(i) = {16{i}} bytes, i=0..10. Stream 11 all-zero beats back-to-back, first with in_first=1 -> out_round 10,9,...,0; out_state = k(r); out_mix=1 only for rounds 9..1; out_last=1 only on the 11th beat. A 12th beat without in_first -> out_round 10 (wrap).
- Hold out_ready=0 with one result held -> in_ready=0; out_* stable for 5 cycles; rnd not advanced. Raise out_ready together with a new in_valid -> reload with no bubble, next out_round = previous-1.
- Same cycle: key_we to addr 10 with a new value, plus an accepted in_first beat -> out_state uses the old key(10). The following in_first beat uses the new value.
- key_we with key_addr=11..15 -> no key entry changes; a 0-state sweep of rounds 10..0 still returns the original keys.
- Pull rst_n low after the round-5 beat and release -> out_valid=0 immediately. The next beat with in_first=0 gives out_round 10.

Source files
------------

// File: rtl/inv_add_round_key.sv
// AES-128 decryption AddRoundKey stage: XORs each accepted state with the
// round key for the internally tracked (descending) round, one register deep.
module inv_add_round_key #(
    parameter int unsigned NR = 10,
    parameter int unsigned SW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_we,
    input  logic [3:0]    key_addr,
    input  logic [0:SW-1] key_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:SW-1] in_state,
    input  logic          in_first,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:SW-1] out_state,
    output logic [3:0]    out_round,
    output logic          out_mix,
    output logic          out_last
);

    localparam int unsigned   RW       = 4;
    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    logic [0:SW-1] r_key [0:NR];
    logic [RW-1:0] r_rnd;
    logic          r_out_valid;
    logic [0:SW-1] r_out_state;
    logic [RW-1:0] r_out_round;
    logic          r_out_mix;
    logic          r_out_last;

    logic          w_accept;
    logic [RW-1:0] w_sel;
    logic [RW-1:0] w_rnd_nxt;
    logic [0:SW-1] w_key;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    // A first beat restarts the schedule at the top round, aborting any block in flight.
    assign w_sel     = in_first ? LAST_RND : r_rnd;
    assign w_key     = r_key[w_sel];
    assign w_rnd_nxt = (w_sel == '0) ? LAST_RND : w_sel - RW'(1);

    // Key bank; the datapath reads the pre-edge contents, so a same-cycle write is seen next beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                r_key[i] <= '0;
            end
        end else if (key_we && (key_addr <= LAST_RND)) begin
            r_key[key_addr] <= key_wdata;
        end
    end

    // Output register and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnd       <= LAST_RND;
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_round <= '0;
            r_out_mix   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_rnd       <= w_rnd_nxt;
            r_out_valid <= 1'b1;
            r_out_state <= in_state ^ w_key;
            r_out_round <= w_sel;
            r_out_mix   <= (w_sel != '0) && (w_sel != LAST_RND);
            r_out_last  <= (w_sel == '0);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_round = r_out_round;
    assign out_mix   = r_out_mix;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_inv_add_round_key.sv
// Bench for inv_add_round_key: scoreboard of hand-derived expectations plus
// directed stall, key-write race, bad-address and mid-block reset sequences.
module tb_inv_add_round_key;

    typedef struct packed {
        logic [0:127] st;
        logic [3:0]   rnd;
        logic         mix;
        logic         last;
    } exp_t;

    typedef struct {
        logic [0:127] st;
        logic         first;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_we = 1'b0;
    logic [3:0]   key_addr = '0;
    logic [0:127] key_wdata = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] in_state = '0;
    logic         in_first = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_state;
    logic [3:0]   out_round;
    logic         out_mix;
    logic         out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vec[12];

    inv_add_round_key #(.NR(10), .SW(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_first(in_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_mix(out_mix), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [0:127] kb(input int b);
        logic [7:0] v;
        v = 8'(b);
        return {16{v}};
    endfunction

    function automatic exp_t mk(input logic [0:127] st, input int r, input logic mix, input logic last);
        exp_t e;
        e.st = st; e.rnd = 4'(r); e.mix = mix; e.last = last;
        return e;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Output monitor: a transfer completes at the next rising edge when valid && ready now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow actual=unexpected_beat round=%0d expected=none", out_round);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat", 192'({out_state, out_round, out_mix, out_last}),
                    192'({e.st, e.rnd, e.mix, e.last}));
            end
        end
    end

    task automatic write_key(input int addr, input logic [0:127] data);
        key_we = 1'b1; key_addr = 4'(addr); key_wdata = data;
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic send(input logic [0:127] st, input logic first, input exp_t e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_state = st; in_first = first;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_first = 1'b0; in_state = '0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++) begin
            int r;
            r = (i < 11) ? 10 - i : 10;
            vec[i].st    = '0;
            vec[i].first = (i == 0);
            vec[i].e     = mk(kb(r), r, (i >= 1 && i <= 9), (i == 10));
        end

        // Reset values.
        repeat (2) @(negedge clk);
        chk("reset_outputs", 192'({out_valid, out_state, out_round, out_mix, out_last, in_ready}),
            192'({1'b0, 128'h0, 4'd0, 1'b0, 1'b0, 1'b1}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // FIPS-197 C.1 final decryption AddRoundKey.
        write_key(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
             mk(128'h7ad5fda789ef4e272bca100b3d9ff59f, 10, 1'b0, 1'b0));
        idle();
        wait_empty();

        // Full round sweep, back to back, then wrap without in_first.
        for (int i = 0; i <= 10; i++) write_key(i, kb(i));
        for (int i = 0; i < 12; i++) send(vec[i].st, vec[i].first, vec[i].e);
        idle();
        wait_empty();

        // Stall: hold one result, output must not move and in_ready must stay low.
        out_ready = 1'b0;
        send('0, 1'b0, mk(kb(9), 9, 1'b1, 1'b0));
        in_valid = 1'b1; in_state = 128'h1; in_first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 192'({in_ready, out_valid, out_state, out_round, out_mix, out_last}),
                192'({1'b0, 1'b1, kb(9), 4'd9, 1'b1, 1'b0}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send('0, 1'b0, mk(kb(8), 8, 1'b1, 1'b0));
        idle();
        @(negedge clk);
        chk("no_bubble", 192'({out_valid, out_round}), 192'({1'b1, 4'd8}));
        wait_empty();

        // Same-cycle key write and accept: old key is used, new key afterwards.
        key_we = 1'b1; key_addr = 4'd10; key_wdata = {16{8'ha5}};
        send('0, 1'b1, mk(kb(10), 10, 1'b0, 1'b0));
        key_we = 1'b0;
        send('0, 1'b1, mk({16{8'ha5}}, 10, 1'b0, 1'b0));
        idle();
        wait_empty();
        write_key(10, kb(10));

        // Out-of-range key addresses must not disturb the bank.
        for (int a = 11; a <= 15; a++) write_key(a, {128{1'b1}});
        for (int i = 0; i < 11; i++) send(vec[i].st, vec[i].first, vec[i].e);
        idle();
        wait_empty();

        // Reset mid-block after the round-5 beat.
        for (int i = 0; i < 5; i++) send(vec[i].st, vec[i].first, vec[i].e);
        idle();
        wait_empty();
        out_ready = 1'b0;
        send(vec[5].st, vec[5].first, vec[5].e);
        idle();
        @(negedge clk);
        chk("held_round5", 192'({out_valid, out_round}), 192'({1'b1, 4'd5}));
        sb.delete();
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", 192'({out_valid, out_state, out_round, out_mix, out_last}),
            192'({1'b0, 128'h0, 4'd0, 1'b0, 1'b0}));
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        // Key bank was cleared too, so the restarted beat carries a zero key.
        send('0, 1'b0, mk('0, 10, 1'b0, 1'b0));
        idle();
        wait_empty();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
